// File: rtl/elevator_call_scheduler.sv
// SCAN-policy call scheduler: latches floor calls and hands one target at a
// time to the car controller, holding a door dwell at each served floor.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS   = 9,
    parameter int DWELL_CYCLES = 10000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [3:0]            current_floor,
    input  logic                  car_idle,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open
);

    localparam int            CW         = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SERVE_UP   = 2'd1;
    localparam logic [1:0] SERVE_DOWN = 2'd2;
    localparam logic [1:0] DWELL      = 2'd3;

    logic [1:0]            state, state_d;
    logic [CW-1:0]         dwell_cnt, dwell_cnt_d;
    logic [NUM_FLOORS-1:0] pending_d, cur_mask, set_mask, clr_mask;
    logic [3:0]            target_floor_d, above, below, up_dist, down_dist;
    logic                  target_valid_d, dir_up_d, door_open_d;
    logic                  floor_ok, here, above_found, below_found, arrived;
    logic                  enter_dwell, go_up, go_down, go_idle;

    // Nearest pending call on each side of the car, plus a one-hot of its floor.
    always_comb begin
        cur_mask    = '0;
        above       = '0;
        above_found = 1'b0;
        below       = '0;
        below_found = 1'b0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending[f] && 4'(f) > current_floor) begin
                above       = 4'(f);
                above_found = 1'b1;
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (4'(f) == current_floor) begin
                cur_mask[f] = 1'b1;
            end
            if (pending[f] && 4'(f) < current_floor) begin
                below       = 4'(f);
                below_found = 1'b1;
            end
        end
    end

    assign floor_ok  = {1'b0, current_floor} < 5'(NUM_FLOORS);
    assign here      = |(pending & cur_mask);
    assign up_dist   = above - current_floor;
    assign down_dist = current_floor - below;
    assign arrived   = car_idle && (current_floor == target_floor);

    always_comb begin
        state_d        = state;
        dwell_cnt_d    = dwell_cnt;
        target_floor_d = target_floor;
        target_valid_d = target_valid;
        dir_up_d       = dir_up;
        door_open_d    = door_open;
        set_mask       = call_req;
        clr_mask       = '0;
        enter_dwell    = 1'b0;
        go_up          = 1'b0;
        go_down        = 1'b0;
        go_idle        = 1'b0;
        pending_d      = pending;

        case (state)
            IDLE: begin
                target_floor_d = current_floor;
                if (here && car_idle) begin
                    enter_dwell = 1'b1;
                end else if (above_found && (!below_found || up_dist <= down_dist)) begin
                    go_up = 1'b1;
                end else if (below_found) begin
                    go_down = 1'b1;
                end
            end
            SERVE_UP: begin
                if (arrived)          enter_dwell = 1'b1;
                else if (above_found) target_floor_d = above;
                else if (below_found) go_down = 1'b1;
                else                  go_idle = 1'b1;
            end
            SERVE_DOWN: begin
                if (arrived)          enter_dwell = 1'b1;
                else if (below_found) target_floor_d = below;
                else if (above_found) go_up = 1'b1;
                else                  go_idle = 1'b1;
            end
            default: begin
                // A press of the floor we are standing at just holds the doors.
                set_mask = call_req & ~cur_mask;
                if (|(call_req & cur_mask)) begin
                    dwell_cnt_d = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    door_open_d = 1'b0;
                    if (dir_up) begin
                        if (above_found)      go_up   = 1'b1;
                        else if (below_found) go_down = 1'b1;
                        else                  go_idle = 1'b1;
                    end else begin
                        if (below_found)      go_down = 1'b1;
                        else if (above_found) go_up   = 1'b1;
                        else                  go_idle = 1'b1;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt + CW'(1);
                end
            end
        endcase

        if (enter_dwell) begin
            state_d        = DWELL;
            door_open_d    = 1'b1;
            target_valid_d = 1'b0;
            target_floor_d = current_floor;
            dwell_cnt_d    = '0;
            clr_mask       = cur_mask;
        end
        if (go_up) begin
            state_d        = SERVE_UP;
            dir_up_d       = 1'b1;
            target_valid_d = 1'b1;
            target_floor_d = above;
        end
        if (go_down) begin
            state_d        = SERVE_DOWN;
            dir_up_d       = 1'b0;
            target_valid_d = 1'b1;
            target_floor_d = below;
        end
        if (go_idle) begin
            state_d        = IDLE;
            target_valid_d = 1'b0;
            target_floor_d = current_floor;
        end

        // Clearing after setting makes an arrival-edge press of that floor vanish.
        pending_d = (pending | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dwell_cnt    <= '0;
            pending      <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
        end else if (floor_ok) begin
            state        <= state_d;
            dwell_cnt    <= dwell_cnt_d;
            pending      <= pending_d;
            target_floor <= target_floor_d;
            target_valid <= target_valid_d;
            dir_up       <= dir_up_d;
            door_open    <= door_open_d;
        end
    end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Latches floor-call buttons and sequences the car through them with a SCAN (sweep) policy. Presents one target floor at a time to the elevator state machine as its `requested_floor`, and watches `current_floor` and the idle indication for arrival. On arrival it clears the served call and holds a door-open dwell. It then picks the next target in the current sweep direction, or reverses when that direction has no calls.

## Interface
- `NUM_FLOORS`, 9: floors 0..NUM_FLOORS-1; legal range 2..16.
- `DWELL_CYCLES`, 10000000: door-open dwell length in clk cycles; minimum 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `call_req` input NUM_FLOORS: bit f is the floor-f button; level or pulse; sampled every edge.
- `current_floor` input 4: car position from the elevator state machine.
- `car_idle` input 1: 1 when the car is stationary (the state machine's idle indication).
- `target_floor` output 4: floor fed to the state machine's `requested_floor`.
- `target_valid` output 1: 1 while a call is being pursued.
- `pending` output NUM_FLOORS: latched, unserved calls.
- `dir_up` output 1: current sweep direction, 1 = up.
- `door_open` output 1: 1 during dwell.

## Operation
- States: IDLE, SERVE_UP, SERVE_DOWN, DWELL. All outputs are registered.
- Pending: `pending[f]` sets on an edge where `call_req[f]`=1. It clears only on arrival at f. Set and clear of the same bit in the same cycle: clear wins, and the press is discarded.
- Search terms, computed combinationally from registered `pending` and `current_floor`:
  - above = lowest pending floor > current_floor.
  - below = highest pending floor < current_floor.
  - here = `pending[current_floor]`.
- IDLE, with `target_valid`=0 and `target_floor`=`current_floor`:
  - here and `car_idle` -> DWELL; clear the bit.
  - else above only -> SERVE_UP.
  - else below only -> SERVE_DOWN.
  - both exist -> go toward the nearer one; equal distance -> up.
  - `dir_up` follows the chosen direction.
- SERVE_UP: `target_floor` = above, re-evaluated every cycle, so a newer call between car and target retargets lower.
  - No above and below exists -> SERVE_DOWN.
  - Neither -> IDLE.
- SERVE_DOWN: mirror image of SERVE_UP, using below.
- Arrival: in SERVE_*, `car_idle`=1 and `current_floor`==`target_floor` -> DWELL; clear `pending[current_floor]`.
- A call at `current_floor` while the car is moving (`car_idle`=0) stays pending and is served on a later sweep.
- DWELL:
  - `door_open`=1, `target_valid`=0, `target_floor`=`current_floor`.
  - The counter runs from 0 to DWELL_CYCLES-1.
  - A press of `current_floor` during dwell restarts the counter and does not set pending.
  - At terminal count, continue in `dir_up` if a call exists that way, else reverse if one exists the other way, else IDLE.
- `current_floor` >= NUM_FLOORS: hold state and all registers. No target is issued.
- `rst` mid-operation: all state lost, pending calls dropped.

## Timing
- Reset values: state IDLE, `pending`=0, `target_floor`=0, `target_valid`=0, `dir_up`=1, `door_open`=0, dwell counter 0.
- `call_req` sampled at edge N -> `pending` visible after N -> `target_valid`/`target_floor` updated after edge N+1 (2-edge latency).
- Arrival detected at edge A -> `door_open`=1 and the pending bit cleared after A.
- `door_open` stays high for exactly DWELL_CYCLES cycles absent a restart. The next `target_valid` appears after the edge ending the dwell.
- A retarget takes effect one edge after the new `pending` bit is visible.
- `target_floor` changes only at clock edges. It never exceeds NUM_FLOORS-1.

## Test plan
Bench uses NUM_FLOORS=9 and DWELL_CYCLES=4, with a behavioral car model that moves one floor per 3 cycles.
- Reset: `rst`=1 for 2 cycles with `call_req`=9'h1FF -> all outputs at reset values, `pending`=0 after release.
- Single call: car at 0, pulse `call_req`[5] -> `target_valid`=1 with `target_floor`=5 two edges later, `dir_up`=1. On arrival, `pending`[5]=0 and `door_open` high for 4 cycles, then IDLE with `target_floor`=5.
- Retarget and sweep: car at 0 heading to 7; press 3 when the car is at 1 -> target becomes 3. After dwell at 3, target becomes 7. After 7, press 2 -> SERVE_DOWN, target 2, `dir_up`=0.
- Nearest-first with tie: car idle at 4, press 2 and 6 in the same cycle -> SERVE_UP to 6 first (tie goes up), then 2.
- Dwell restart and same-floor press: during dwell at 3, press 3 at count 2 -> `door_open` lasts 4 more cycles and `pending`[3] stays 0. Press at arrival edge -> discarded.
- Reset mid-run: assert `rst` while moving toward 8 with calls {2, 8} pending -> next edge `pending`=0, `target_valid`=0, state IDLE.
